p08_vga_sync: RTL and testbench

- VGA timing generator; the producer end of the pixel-mux interface.
- Drives the `visible` qualifier plus hpos/vpos.
- Layer generators (wall, map, debug) use hpos/vpos; the pixel mux gates its colour output with `visible`; hsync/vsync go to the pins.
- Default timing is 640x480@60 on a 25.175 MHz pixel rate, with an optional pixel-clock enable.

---
 rtl/p08_vga_pkg.sv | 29 ++
 rtl/p08_vga_wrap_counter.sv | 47 ++++
 rtl/p08_vga_sync.sv | 143 ++++++++++++++
 tb/tb_p08_vga_sync.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p08_vga_pkg.sv
// p08_vga_pkg: shared VGA timing definitions for the sync generator, layer
// generators and pixel mux.
//   - default 640x480@60 timing constants and the derived line/frame totals
//   - position width and position type
//   - in_window(): half-open range test used for sync pulse decoding
package p08_vga_pkg;

   localparam int unsigned VGA_POS_W   = 10;

   localparam int unsigned VGA_H_VIEW  = 640;
   localparam int unsigned VGA_H_FRONT = 16;
   localparam int unsigned VGA_H_SYNC  = 96;
   localparam int unsigned VGA_H_BACK  = 48;
   localparam int unsigned VGA_V_VIEW  = 480;
   localparam int unsigned VGA_V_FRONT = 10;
   localparam int unsigned VGA_V_SYNC  = 2;
   localparam int unsigned VGA_V_BACK  = 33;

   localparam int unsigned VGA_H_TOTAL = VGA_H_VIEW + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
   localparam int unsigned VGA_V_TOTAL = VGA_V_VIEW + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

   typedef logic [VGA_POS_W-1:0] vga_pos_t;

   // True when pos lies in [lo, lo+len).
   function automatic logic in_window(vga_pos_t pos, int unsigned lo, int unsigned len);
      return (32'(pos) >= lo) && (32'(pos) < lo + len);
   endfunction

endpackage

// File: rtl/p08_vga_wrap_counter.sv
// p08_vga_wrap_counter: modulo (MAX+1) up-counter used for the VGA beam
// position.
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset; value resets to MAX
//   inc        in   advance the count on this clock edge
//   value      out  current count (registered)
//   value_next out  count that will be loaded on the next edge
//   wrap       out  inc is high while value == MAX (count returns to 0)
module p08_vga_wrap_counter #(
   parameter int unsigned MAX   = 799,
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] value_next,
   output logic             wrap
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;
   logic             wrap_d;

   always_comb begin
      wrap_d  = inc && (value_q == WIDTH'(MAX));
      value_d = value_q;
      if (wrap_d) begin
         value_d = '0;
      end else if (inc) begin
         value_d = value_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= WIDTH'(MAX);
      end else begin
         value_q <= value_d;
      end
   end

   assign value      = value_q;
   assign value_next = value_d;
   assign wrap       = wrap_d;

endmodule

// File: rtl/p08_vga_sync.sv
// p08_vga_sync: VGA timing generator, producer side of the pixel-mux
// interface.
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   en           in   pixel advance enable (tie high when clk is the pixel clock)
//   hpos         out  current column, 0..H_TOTAL-1
//   vpos         out  current line, 0..V_TOTAL-1
//   visible      out  hpos < H_VIEW and vpos < V_VIEW
//   hsync        out  horizontal sync, active level HSYNC_POL
//   vsync        out  vertical sync, active level VSYNC_POL
//   line_end     out  one-clock pulse when hpos wraps to 0
//   frame_start  out  one-clock pulse when (hpos,vpos) becomes (0,0)
//   frame_count  out  8-bit frame counter, present only when the macro
//                     VGA_SYNC_FRAME_COUNT_EN is defined
// Reset parks the beam at (H_TOTAL-1, V_TOTAL-1) so the first enabled
// pixel is (0,0) with frame_start asserted.
module p08_vga_sync
   import p08_vga_pkg::*;
#(
   parameter int unsigned H_VIEW    = VGA_H_VIEW,
   parameter int unsigned H_FRONT   = VGA_H_FRONT,
   parameter int unsigned H_SYNC    = VGA_H_SYNC,
   parameter int unsigned H_BACK    = VGA_H_BACK,
   parameter int unsigned V_VIEW    = VGA_V_VIEW,
   parameter int unsigned V_FRONT   = VGA_V_FRONT,
   parameter int unsigned V_SYNC    = VGA_V_SYNC,
   parameter int unsigned V_BACK    = VGA_V_BACK,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   output logic [VGA_POS_W-1:0] hpos,
   output logic [VGA_POS_W-1:0] vpos,
   output logic                 visible,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 line_end,
   output logic                 frame_start
`ifdef VGA_SYNC_FRAME_COUNT_EN
   ,
   output logic [7:0]           frame_count
`endif
);

   localparam int unsigned H_TOT = H_VIEW + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOT = V_VIEW + V_FRONT + V_SYNC + V_BACK;

   if ((H_TOT > (1 << VGA_POS_W)) || (V_TOT > (1 << VGA_POS_W))) begin : g_bad_timing
      $error("p08_vga_sync: H_TOTAL and V_TOTAL must each be <= 1024");
   end

   logic [VGA_POS_W-1:0] h_next;
   logic [VGA_POS_W-1:0] v_next;
   logic                 h_wrap;
   logic                 v_wrap;
   logic                 v_inc;

   assign v_inc = en & h_wrap;

   p08_vga_wrap_counter #(
      .MAX   (H_TOT - 1),
      .WIDTH (VGA_POS_W)
   ) u_hcnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc        (en),
      .value      (hpos),
      .value_next (h_next),
      .wrap       (h_wrap)
   );

   p08_vga_wrap_counter #(
      .MAX   (V_TOT - 1),
      .WIDTH (VGA_POS_W)
   ) u_vcnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc        (v_inc),
      .value      (vpos),
      .value_next (v_next),
      .wrap       (v_wrap)
   );

   logic visible_q, visible_d;
   logic hsync_q, hsync_d;
   logic vsync_q, vsync_d;
   logic line_end_q, line_end_d;
   logic frame_start_q, frame_start_d;

   // Flags decode the counters' next values so they register in the same
   // edge as the position they describe. With en low the next values equal
   // the current ones, so the flags hold while the pulses fall.
   always_comb begin
      visible_d     = (32'(h_next) < H_VIEW) && (32'(v_next) < V_VIEW);
      hsync_d       = in_window(h_next, H_VIEW + H_FRONT, H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = in_window(v_next, V_VIEW + V_FRONT, V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      line_end_d    = h_wrap;
      frame_start_d = v_wrap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         visible_q     <= 1'b0;
         hsync_q       <= ~HSYNC_POL;
         vsync_q       <= ~VSYNC_POL;
         line_end_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         visible_q     <= visible_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_end_q    <= line_end_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign visible     = visible_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign line_end    = line_end_q;
   assign frame_start = frame_start_q;

`ifdef VGA_SYNC_FRAME_COUNT_EN
   logic [7:0] frame_count_q, frame_count_d;

   always_comb begin
      frame_count_d = frame_count_q + {7'd0, frame_start_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_count_q <= '0;
      end else begin
         frame_count_q <= frame_count_d;
      end
   end

   assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_p08_vga_sync.sv
// tb_p08_vga_sync: self-checking bench for p08_vga_sync.
// Two instances: default 640x480 timing, and a tiny 12x7 timing with
// active-high hsync so whole frames fit in a short run.
module tb_p08_vga_sync;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic en    = 1'b0;

   logic [9:0] h0, v0, h1, v1;
   logic       vis0, hs0, vs0, le0, fs0;
   logic       vis1, hs1, vs1, le1, fs1;
`ifdef VGA_SYNC_FRAME_COUNT_EN
   logic [7:0] fc0, fc1;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   p08_vga_sync dut0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .hpos        (h0),
      .vpos        (v0),
      .visible     (vis0),
      .hsync       (hs0),
      .vsync       (vs0),
      .line_end    (le0),
      .frame_start (fs0)
`ifdef VGA_SYNC_FRAME_COUNT_EN
      ,
      .frame_count (fc0)
`endif
   );

   p08_vga_sync #(
      .H_VIEW    (8),
      .H_FRONT   (1),
      .H_SYNC    (2),
      .H_BACK    (1),
      .V_VIEW    (4),
      .V_FRONT   (1),
      .V_SYNC    (1),
      .V_BACK    (1),
      .HSYNC_POL (1'b1),
      .VSYNC_POL (1'b0)
   ) dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .hpos        (h1),
      .vpos        (v1),
      .visible     (vis1),
      .hsync       (hs1),
      .vsync       (vs1),
      .line_end    (le1),
      .frame_start (fs1)
`ifdef VGA_SYNC_FRAME_COUNT_EN
      ,
      .frame_count (fc1)
`endif
   );

   typedef struct {
      int hv, hf, hs, hb, vv, vf, vs, vb;
      bit hp, vp;
   } timing_t;

   typedef struct {
      int h, v;
      bit vis, hsy, vsy, le, fs;
      int fc;
   } exp_t;

   timing_t t0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
   timing_t t1 = '{8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b0};

   // Model state: number of enabled advances since reset, and whether the
   // most recent edge was an advance.
   int k   = 0;
   bit adv = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k   <= 0;
         adv <= 1'b0;
      end else begin
         adv <= en;
         if (en) k <= k + 1;
      end
   end

   // The beam walks a linear index through the frame; reset sits one step
   // before index 0.
   function automatic exp_t model(timing_t t, int kk, bit a);
      exp_t e;
      int ht, vt, n, lin;
      ht    = t.hv + t.hf + t.hs + t.hb;
      vt    = t.vv + t.vf + t.vs + t.vb;
      n     = ht * vt;
      lin   = (kk + n - 1) % n;
      e.h   = lin % ht;
      e.v   = lin / ht;
      e.vis = (e.h < t.hv) && (e.v < t.vv);
      e.hsy = (e.h >= t.hv + t.hf && e.h < t.hv + t.hf + t.hs) ? t.hp : !t.hp;
      e.vsy = (e.v >= t.vv + t.vf && e.v < t.vv + t.vf + t.vs) ? t.vp : !t.vp;
      e.le  = a && (e.h == 0);
      e.fs  = a && (lin == 0);
      e.fc  = (kk == 0) ? 0 : (((kk - 1) / n) + 1) % 256;
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   exp_t e0, e1;

   always @(negedge clk) begin
      e0 = model(t0, k, adv);
      e1 = model(t1, k, adv);
      chk("m0_hpos", int'(h0), e0.h);
      chk("m0_vpos", int'(v0), e0.v);
      chk("m0_visible", int'(vis0), int'(e0.vis));
      chk("m0_hsync", int'(hs0), int'(e0.hsy));
      chk("m0_vsync", int'(vs0), int'(e0.vsy));
      chk("m0_line_end", int'(le0), int'(e0.le));
      chk("m0_frame_start", int'(fs0), int'(e0.fs));
      chk("m1_hpos", int'(h1), e1.h);
      chk("m1_vpos", int'(v1), e1.v);
      chk("m1_visible", int'(vis1), int'(e1.vis));
      chk("m1_hsync", int'(hs1), int'(e1.hsy));
      chk("m1_vsync", int'(vs1), int'(e1.vsy));
      chk("m1_line_end", int'(le1), int'(e1.le));
      chk("m1_frame_start", int'(fs1), int'(e1.fs));
`ifdef VGA_SYNC_FRAME_COUNT_EN
      chk("m0_frame_count", int'(fc0), e0.fc);
      chk("m1_frame_count", int'(fc1), e1.fc);
`endif
   end

   task automatic step(input logic e);
      en = e;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int hs_low_cnt, hs_min, hs_max, vis_cnt, vis_low_min;
      int fs_cnt, vis1_cnt, vs1_cnt, vs1_badrow, hs1_cnt;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_hpos0", int'(h0), 799);
      chk("rst_vpos0", int'(v0), 524);
      chk("rst_vis0", int'(vis0), 0);
      chk("rst_hsync0", int'(hs0), 1);
      chk("rst_vsync0", int'(vs0), 1);
      chk("rst_le0", int'(le0), 0);
      chk("rst_fs0", int'(fs0), 0);
      chk("rst_hpos1", int'(h1), 11);
      chk("rst_vpos1", int'(v1), 6);
      chk("rst_hsync1", int'(hs1), 0);

      rst_n = 1'b1;
      step(1'b0);
      chk("idle_hpos0", int'(h0), 799);
      chk("idle_fs0", int'(fs0), 0);

      step(1'b1);
      chk("clk1_hpos0", int'(h0), 0);
      chk("clk1_vpos0", int'(v0), 0);
      chk("clk1_vis0", int'(vis0), 1);
      chk("clk1_fs0", int'(fs0), 1);
      chk("clk1_le0", int'(le0), 1);
      chk("clk1_fs1", int'(fs1), 1);
      step(1'b1);
      chk("clk2_hpos0", int'(h0), 1);
      chk("clk2_fs0", int'(fs0), 0);
      chk("clk2_le0", int'(le0), 0);

      // One line on the default timing: samples hpos 2..799 then (0,1).
      hs_low_cnt = 0; hs_min = 9999; hs_max = -1; vis_cnt = 0; vis_low_min = 9999;
      for (int i = 0; i < 799; i++) begin
         step(1'b1);
         if (hs0 == 1'b0) begin
            hs_low_cnt++;
            if (int'(h0) < hs_min) hs_min = int'(h0);
            if (int'(h0) > hs_max) hs_max = int'(h0);
         end
         if (vis0) vis_cnt++;
         else if (v0 == 10'd0 && int'(h0) < vis_low_min) vis_low_min = int'(h0);
      end
      chk("line_hs_low_cnt", hs_low_cnt, 96);
      chk("line_hs_min", hs_min, 656);
      chk("line_hs_max", hs_max, 751);
      chk("line_vis_cnt", vis_cnt, 639);
      chk("line_vis_low_first", vis_low_min, 640);
      chk("wrap_hpos", int'(h0), 0);
      chk("wrap_vpos", int'(v0), 1);
      chk("wrap_le", int'(le0), 1);
      step(1'b1);
      chk("after_wrap_le", int'(le0), 0);

      // Enable toggled 1,0,0,1 around hpos 799.
      repeat (798) step(1'b1);
      chk("tog_at799", int'(h0), 799);
      step(1'b0);
      chk("tog_hold1", int'(h0), 799);
      chk("tog_hold1_le", int'(le0), 0);
      step(1'b0);
      chk("tog_hold2", int'(h0), 799);
      step(1'b1);
      chk("tog_adv_hpos", int'(h0), 0);
      chk("tog_adv_vpos", int'(v0), 2);
      chk("tog_adv_le", int'(le0), 1);
      step(1'b0);
      chk("tog_le_drop", int'(le0), 0);
      chk("tog_hold_hpos", int'(h0), 0);

      // Asynchronous reset mid-line at (300,2).
      repeat (300) step(1'b1);
      chk("pre_rst_hpos", int'(h0), 300);
      chk("pre_rst_vis", int'(vis0), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_hpos", int'(h0), 799);
      chk("arst_vpos", int'(v0), 524);
      chk("arst_vis", int'(vis0), 0);
      chk("arst_hsync1", int'(hs1), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1);
      chk("rst_restart_hpos", int'(h0), 0);
      chk("rst_restart_vpos", int'(v0), 0);
      chk("rst_restart_fs", int'(fs0), 1);

      // One whole frame on the small timing (84 samples from (0,0)).
      fs_cnt = 0; vis1_cnt = 0; vs1_cnt = 0; vs1_badrow = 0; hs1_cnt = 0;
      for (int i = 0; i < 84; i++) begin
         if (fs1) fs_cnt++;
         if (vis1) vis1_cnt++;
         if (vs1 == 1'b0) begin
            vs1_cnt++;
            if (v1 != 10'd5) vs1_badrow++;
         end
         if (hs1) hs1_cnt++;
         step(1'b1);
      end
      chk("frame_fs_cnt", fs_cnt, 1);
      chk("frame_vis_cnt", vis1_cnt, 32);
      chk("frame_vsync_cnt", vs1_cnt, 12);
      chk("frame_vsync_row", vs1_badrow, 0);
      chk("frame_hsync_cnt", hs1_cnt, 14);

      // Run on to 257 small frames since restart.
      repeat (21252) step(1'b1);
`ifdef VGA_SYNC_FRAME_COUNT_EN
      chk("fc_255", int'(fc1), 255);
`endif
      repeat (84) step(1'b1);
`ifdef VGA_SYNC_FRAME_COUNT_EN
      chk("fc_wrap0", int'(fc1), 0);
`endif
      repeat (84) step(1'b1);
`ifdef VGA_SYNC_FRAME_COUNT_EN
      chk("fc_end1", int'(fc1), 1);
      chk("fc0_one", int'(fc0), 1);
`endif
      chk("end_hpos1", int'(h1), 0);
      chk("end_vpos1", int'(v1), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
